// File: rtl/dmem_resp.sv
// dmem_resp: word RAM with byte-lane stores and programmable wait states.
// INIT_FILE parameter is present when DMEM_INIT_EN is defined.
module dmem_resp #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
`ifdef DMEM_INIT_EN
  ,
  parameter string INIT_FILE = "dmem.hex"
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [3:0]        DWea,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Data_wr,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       Data_rd,
  output logic              err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           pend_data;
  logic                  pend_err;
  logic                  wait_done;
  logic                  unused_ok;

  assign unused_ok = ^Addr[1:0];

  assign ready     = !rst && (state != S_WAIT);
  assign accept    = req && ready;
  assign rvalid    = (state == S_RESP);
  assign idx       = Addr[DEPTH_LOG2+1:2];
  assign in_range  = (Addr >> (DEPTH_LOG2 + 2)) == '0;
  assign rd_word   = in_range ? mem[idx] : 32'h0;
  assign wait_done = (state == S_WAIT) && (cnt == 4'd0);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WLOAD;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_RESP;
        else cnt_nx = cnt - 4'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Response capture: sampled on accept, published on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      Data_rd   <= 32'h0;
      err       <= 1'b0;
      pend_data <= 32'h0;
      pend_err  <= 1'b0;
    end else begin
      if (accept) begin
        pend_data <= rd_word;
        pend_err  <= !in_range;
      end
      if (accept && (WAIT_CYCLES == 0)) begin
        Data_rd <= rd_word;
        err     <= !in_range;
      end else if (wait_done) begin
        Data_rd <= pend_data;
        err     <= pend_err;
      end
    end
  end

  // Byte-lane store commit on the accept edge (RAM is never reset)
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (DWea[i]) mem[idx][8*i +: 8] <= Data_wr[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks on three instances
// with WAIT_CYCLES of 0, 2 and 3.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req  [3];
  logic [3:0]  we   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic        er   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .DWea(we[0]),
    .Addr(addr[0]), .Data_wr(wd[0]), .ready(rdy[0]),
    .rvalid(rv[0]), .Data_rd(rd[0]), .err(er[0])
  );

  dmem_resp #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .DWea(we[1]),
    .Addr(addr[1]), .Data_wr(wd[1]), .ready(rdy[1]),
    .rvalid(rv[1]), .Data_rd(rd[1]), .err(er[1])
  );

  dmem_resp #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .DWea(we[2]),
    .Addr(addr[2]), .Data_wr(wd[2]), .ready(rdy[2]),
    .rvalid(rv[2]), .Data_rd(rd[2]), .err(er[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic r,
                     input logic [3:0] w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    req[k]  = r;
    we[k]   = w;
    addr[k] = a;
    wd[k]   = d;
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < 3; k++) put(k, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_rvalid%0d", k), 32'(rv[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), rd[k], 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(er[k]), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_ready0", 32'(rdy[0]), 32'd1);

    // WAIT_CYCLES=0: store, overwrite, load back-to-back
    put(0, 1'b1, 4'hF, 32'h10, 32'h12345678);
    step();
    chk("st1_rvalid", 32'(rv[0]), 32'd1);
    put(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step();
    chk("st2_prewrite", rd[0], 32'h12345678);
    chk("st2_err", 32'(er[0]), 32'd0);
    chk("st2_ready", 32'(rdy[0]), 32'd1);
    put(0, 1'b1, 4'h0, 32'h10, 32'h0);
    step();
    chk("ld_rvalid", 32'(rv[0]), 32'd1);
    chk("ld_data", rd[0], 32'hDEADBEEF);
    chk("ld_ready", 32'(rdy[0]), 32'd1);
    put(0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("idle_rvalid", 32'(rv[0]), 32'd0);
    chk("idle_hold", rd[0], 32'hDEADBEEF);

    // Byte lane write
    put(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    step();
    put(0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00);
    step();
    chk("lane_prewrite", rd[0], 32'h11223344);
    put(0, 1'b1, 4'h0, 32'h20, 32'h0);
    step();
    chk("lane_data", rd[0], 32'h1122AA44);
    put(0, 1'b1, 4'b0110, 32'h20, 32'h77665544);
    step();
    put(0, 1'b1, 4'h0, 32'h23, 32'h0);
    step();
    chk("lane_mixed", rd[0], 32'h11665544);

    // Out of range
    put(0, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5);
    step();
    put(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    step();
    chk("oor_st_rvalid", 32'(rv[0]), 32'd1);
    chk("oor_st_err", 32'(er[0]), 32'd1);
    chk("oor_st_data", rd[0], 32'h0);
    put(0, 1'b1, 4'h0, 32'h0, 32'h0);
    step();
    chk("oor_ld0_data", rd[0], 32'hA5A5A5A5);
    chk("oor_ld0_err", 32'(er[0]), 32'd0);
    put(0, 1'b1, 4'h0, 32'h80000010, 32'h0);
    step();
    chk("oor_ld_err", 32'(er[0]), 32'd1);
    chk("oor_ld_data", rd[0], 32'h0);
    put(0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    // WAIT_CYCLES=2
    put(1, 1'b1, 4'hF, 32'h8, 32'h0BADF00D);
    step();
    put(1, 1'b1, 4'h0, 32'h8, 32'h0);
    chk("w2_t1_ready", 32'(rdy[1]), 32'd0);
    chk("w2_t1_rvalid", 32'(rv[1]), 32'd0);
    step();
    chk("w2_t2_ready", 32'(rdy[1]), 32'd0);
    chk("w2_t2_rvalid", 32'(rv[1]), 32'd0);
    step();
    chk("w2_resp_rvalid", 32'(rv[1]), 32'd1);
    chk("w2_resp_ready", 32'(rdy[1]), 32'd1);
    chk("w2_resp_err", 32'(er[1]), 32'd0);
    step();
    put(1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("w2_reacc_ready", 32'(rdy[1]), 32'd0);
    chk("w2_reacc_rvalid", 32'(rv[1]), 32'd0);
    step();
    chk("w2_w_rvalid", 32'(rv[1]), 32'd0);
    step();
    chk("w2_ld_rvalid", 32'(rv[1]), 32'd1);
    chk("w2_ld_data", rd[1], 32'h0BADF00D);
    step();
    chk("w2_end_rvalid", 32'(rv[1]), 32'd0);
    chk("w2_end_ready", 32'(rdy[1]), 32'd1);
    chk("w2_end_hold", rd[1], 32'h0BADF00D);

    // WAIT_CYCLES=3, reset during WAIT
    put(2, 1'b1, 4'hF, 32'h40, 32'h55AA55AA);
    step();
    put(2, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    #1;
    chk("w3_rst_ready", 32'(rdy[2]), 32'd0);
    step();
    chk("w3_rst_rvalid", 32'(rv[2]), 32'd0);
    chk("w3_rst_ready2", 32'(rdy[2]), 32'd0);
    rst = 1'b0;
    #1;
    chk("w3_after_ready", 32'(rdy[2]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rv[2]) seen = 1'b1;
    end
    chk("w3_dropped", 32'(seen), 32'd0);
    put(2, 1'b1, 4'h0, 32'h40, 32'h0);
    step();
    put(2, 1'b0, 4'h0, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rv[2]) seen = 1'b1;
      else step();
    end
    chk("w3_ld_rvalid", 32'(seen), 32'd1);
    chk("w3_ld_data", rd[2], 32'h55AA55AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
